cpu_tstate_sequencer: RTL and testbench

Downstream consumer of the CPU clock divider. Turns a slow divided tick into single-cycle CPU enables on the system clock, and drives the instruction T-state counter (microstep ring) with run, halt and single-step control. All CPU datapath registers sit on `clk` and qualify with `cpu_en`. Microcode decode uses `t_state` and `t_onehot`.

---
 rtl/cpu_tstate_sequencer_pkg.sv | 14 +
 rtl/cpu_tstate_sequencer_edge_sync.sv | 56 +++++
 rtl/cpu_tstate_sequencer.sv | 136 +++++++++++++
 tb/tb_cpu_tstate_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_tstate_sequencer_pkg.sv
// Shared types and default sizing for the CPU T-state sequencer.
// Imported by cpu_tstate_sequencer; the FSM encoding lives here so decode logic can share it.
package cpu8_seq_pkg;

    typedef enum logic [1:0] {
        HALT       = 2'd0,
        RUN        = 2'd1,
        STEP_ARMED = 2'd2
    } seq_state_t;

    localparam int DEF_NUM_T = 6;
    localparam int DEF_T_W   = 3;

endpackage

// File: rtl/cpu_tstate_sequencer_edge_sync.sv
// Rising-edge detector for a slow level (divided tick or step button).
// CPU8_SEQ_SYNC_EN adds a metastability flop in front of the sampling register.
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic stage_in;
    logic fill_in;
    logic samp_reg;
    logic valid_reg;
    logic prev_reg;
    logic armed_reg;

`ifdef CPU8_SEQ_SYNC_EN
    logic meta_reg;
    logic meta_fill_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_reg      <= 1'b0;
            meta_fill_reg <= 1'b0;
        end else begin
            meta_reg      <= d;
            meta_fill_reg <= 1'b1;
        end
    end

    assign stage_in = meta_reg;
    assign fill_in  = meta_fill_reg;
`else
    assign stage_in = d;
    assign fill_in  = 1'b1;
`endif

    // The detector only arms after a genuine low level has reached the sampling
    // register, so an input held high across reset release never fires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp_reg  <= 1'b0;
            valid_reg <= 1'b0;
            prev_reg  <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            samp_reg  <= stage_in;
            valid_reg <= fill_in;
            prev_reg  <= samp_reg;
            armed_reg <= armed_reg | (valid_reg & ~samp_reg);
        end
    end

    assign rise = samp_reg & ~prev_reg & armed_reg;

endmodule

// File: rtl/cpu_tstate_sequencer.sv
// Turns divided ticks into single-cycle cpu_en pulses and drives the T-state ring
// with run / halt / single-step control. CPU8_SEQ_SYNC_EN selects synchronized inputs.
module cpu_tstate_sequencer
    import cpu8_seq_pkg::*;
#(
    parameter int NUM_T = DEF_NUM_T,
    parameter int T_W   = DEF_T_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             run,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             t_rst,
    output logic             cpu_en,
    output logic [T_W-1:0]   t_state,
    output logic [NUM_T-1:0] t_onehot,
    output logic             halted,
    output logic             instr_done
);

    localparam logic [T_W-1:0] T_LAST = T_W'(NUM_T - 1);

    logic tick_ev;
    logic step_ev;

    edge_sync u_tick_sync (
        .clk   (clk),
        .reset (reset),
        .d     (tick_in),
        .rise  (tick_ev)
    );

    edge_sync u_step_sync (
        .clk   (clk),
        .reset (reset),
        .d     (step_req),
        .rise  (step_ev)
    );

    seq_state_t     state_reg,  state_next;
    logic           cpu_en_reg, cpu_en_next;
    logic [T_W-1:0] t_state_reg, t_next;
    logic           done_reg,   done_next;
    logic           halted_reg;
    logic           block_reg,  block_next;
    logic           run_eff;

    // After a microcode HLT the run level must be dropped and reasserted before
    // the sequencer will free-run again.
    assign run_eff = run & ~block_reg;

    always_comb begin
        state_next  = state_reg;
        cpu_en_next = 1'b0;
        t_next      = t_state_reg;
        done_next   = 1'b0;
        block_next  = run ? block_reg : 1'b0;

        case (state_reg)
            HALT: begin
                if (run_eff) begin
                    state_next = RUN;
                end else if (step_ev) begin
                    state_next = STEP_ARMED;
                end
            end
            RUN: begin
                if (!run) begin
                    state_next = HALT;
                end else if (tick_ev) begin
                    cpu_en_next = 1'b1;
                end
            end
            STEP_ARMED: begin
                if (run_eff) begin
                    state_next  = RUN;
                    cpu_en_next = tick_ev;
                end else if (tick_ev) begin
                    cpu_en_next = 1'b1;
                    state_next  = HALT;
                end
            end
            default: begin
                state_next = HALT;
            end
        endcase

        if (cpu_en_reg) begin
            if (halt_req) begin
                t_next      = '0;
                done_next   = 1'b1;
                state_next  = HALT;
                cpu_en_next = 1'b0;
                block_next  = 1'b1;
            end else if (t_rst || (t_state_reg == T_LAST)) begin
                t_next    = '0;
                done_next = 1'b1;
            end else begin
                t_next = t_state_reg + T_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= HALT;
            cpu_en_reg  <= 1'b0;
            t_state_reg <= '0;
            done_reg    <= 1'b0;
            halted_reg  <= 1'b1;
            block_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cpu_en_reg  <= cpu_en_next;
            t_state_reg <= t_next;
            done_reg    <= done_next;
            halted_reg  <= (state_next == HALT);
            block_reg   <= block_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_T; gi++) begin : g_onehot
            assign t_onehot[gi] = (t_state_reg == T_W'(gi));
        end
    endgenerate

    assign cpu_en     = cpu_en_reg;
    assign t_state    = t_state_reg;
    assign instr_done = done_reg;
    assign halted     = halted_reg;

endmodule

// File: tb/tb_cpu_tstate_sequencer.sv
// Scoreboard bench for cpu_tstate_sequencer: stimulus queues expected cpu_en events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_cpu_tstate_sequencer;

    localparam int NUM_T = 6;
    localparam int T_W   = 3;
`ifdef CPU8_SEQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    localparam int M_HALT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_ARMED = 2;

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic             tick_in  = 1'b0;
    logic             run      = 1'b0;
    logic             step_req = 1'b0;
    logic             halt_req = 1'b0;
    logic             t_rst    = 1'b0;
    logic             cpu_en;
    logic [T_W-1:0]   t_state;
    logic [NUM_T-1:0] t_onehot;
    logic             halted;
    logic             instr_done;

    cpu_tstate_sequencer #(.NUM_T(NUM_T), .T_W(T_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_in    (tick_in),
        .run        (run),
        .step_req   (step_req),
        .halt_req   (halt_req),
        .t_rst      (t_rst),
        .cpu_en     (cpu_en),
        .t_state    (t_state),
        .t_onehot   (t_onehot),
        .halted     (halted),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int exp_cyc;
        int cur_t;
        int nxt_t;
        int done;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference model: operating mode, current T-state, and whether run must be released.
    int m_mode    = M_HALT;
    int m_t       = 0;
    bit m_blocked = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        check("rst_cpu_en", cpu_en, 0);
        check("rst_t_state", t_state, 0);
        check("rst_t_onehot", t_onehot, 1);
        check("rst_halted", halted, 1);
        check("rst_instr_done", instr_done, 0);
        sb.delete();
        m_mode    = M_HALT;
        m_t       = 0;
        m_blocked = 1'b0;
        wait_cycles(3);
        reset = 1'b1;
        if (run) m_mode = M_RUN;
        wait_cycles(4);
    endtask

    task automatic set_run(input bit v);
        run = v;
        if (!v) begin
            m_blocked = 1'b0;
            if (m_mode == M_RUN) m_mode = M_HALT;
        end else if (!m_blocked) begin
            m_mode = M_RUN;
        end
        wait_cycles(2);
        check("halted_after_run", halted, int'(m_mode == M_HALT));
    endtask

    task automatic step();
        step_req = 1'b1;
        wait_cycles(3);
        step_req = 1'b0;
        wait_cycles(4);
        if (m_mode == M_HALT) m_mode = M_ARMED;
        check("halted_after_step", halted, int'(m_mode == M_HALT));
    endtask

    task automatic tick(input bit hr, input bit tr);
        exp_t e;
        halt_req = hr;
        t_rst    = tr;
        @(posedge clk);
        #1;
        tick_in = 1'b1;
        if (m_mode != M_HALT) begin
            e.exp_cyc = cyc + LAT;
            e.cur_t   = m_t;
            if (hr) begin
                e.nxt_t   = 0;
                e.done    = 1;
                m_blocked = run;
                m_mode    = M_HALT;
            end else if (tr || m_t == NUM_T - 1) begin
                e.nxt_t = 0;
                e.done  = 1;
            end else begin
                e.nxt_t = m_t + 1;
                e.done  = 0;
            end
            if (m_mode == M_ARMED) m_mode = M_HALT;
            m_t = e.nxt_t;
            sb.push_back(e);
        end
        wait_cycles(4);
        tick_in = 1'b0;
        wait_cycles(4);
        check("queue_drained", sb.size(), 0);
        check("halted", halted, int'(m_mode == M_HALT));
        check("t_state", t_state, m_t);
        check("t_onehot", t_onehot, 1 << m_t);
        halt_req = 1'b0;
        t_rst    = 1'b0;
    endtask

    // Monitor: consumes one expected entry per observed cpu_en pulse.
    initial begin
        bit   pend;
        exp_t pe;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pend = 1'b0;
            end else if (pend) begin
                check("cpu_en_width", cpu_en, 0);
                check("t_state_next", t_state, pe.nxt_t);
                check("instr_done", instr_done, pe.done);
                pend = 1'b0;
            end else begin
                check("instr_done_idle", instr_done, 0);
                if (cpu_en) begin
                    if (sb.size() == 0) begin
                        check("unexpected_cpu_en", cpu_en, 0);
                    end else begin
                        pe = sb.pop_front();
                        check("cpu_en_latency", cyc, pe.exp_cyc);
                        check("t_state_exec", t_state, pe.cur_t);
                        check("t_onehot_exec", t_onehot, 1 << pe.cur_t);
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        int r;

        // Tick held high across reset release with run=1: no event until a fresh rise.
        run     = 1'b1;
        tick_in = 1'b1;
        #2;
        apply_reset();
        wait_cycles(6);
        check("held_tick_t_state", t_state, 0);
        tick_in = 1'b0;
        wait_cycles(4);

        // Free run through one full instruction and into the next.
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b0);

        // End-of-instruction at T2.
        for (int i = 0; i < NUM_T && m_t != 2; i++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);

        // HLT at T4 while run stays high; requires run to be toggled.
        for (int i = 0; i < NUM_T && m_t != 4; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        set_run(1'b0);
        set_run(1'b1);
        tick(1'b0, 1'b0);

        // Single-step from a clean reset.
        run = 1'b0;
        apply_reset();
        step();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        step();
        tick(1'b0, 1'b0);

        // Randomized mix of run changes, steps and ticks.
        set_run(1'b1);
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) set_run(1'($urandom_range(0, 1)));
            else if (r == 1) step();
            else tick(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 5) == 0));
        end

        // Asynchronous reset landing inside a cpu_en cycle.
        set_run(1'b1);
        tick(1'b0, 1'b0);
        halt_req = 1'b0;
        t_rst    = 1'b0;
        @(posedge clk);
        #1;
        tick_in = 1'b1;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_cycles(1);
            if (cpu_en) begin
                found = 1'b1;
                break;
            end
        end
        check("async_rst_cpu_en_seen", found, 1);
        apply_reset();
        tick_in = 1'b0;
        wait_cycles(4);
        tick(1'b0, 1'b0);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
